poker_deal_sequencer: RTL and testbench

POKER_DEAL_SEQUENCER -- requirements
Module: poker_deal_sequencer

---
 rtl/poker_deal_sequencer_if.sv | 57 +++++
 rtl/poker_deal_sequencer.sv | 173 +++++++++++++++++
 tb/tb_poker_deal_sequencer.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/poker_deal_sequencer_if.sv
// Deal/evaluate bundle between a poker round sequencer and its host.
// slave: sequencer side; master: host/evaluator side. Scores need POKER_SCORE_EN.
interface poker_deal_sequencer_if;
  logic        start_button;
  logic [15:0] rand_in;
  logic        eval_done;
  logic        winner_in;
  logic        tie_in;
  logic        card_wr_en;
  logic [3:0]  card_wr_idx;
  logic [5:0]  card_wr_num;
  logic        start_computation;
  logic        busy;
  logic        result_valid;
  logic        winner;
  logic        tie;
  logic        eval_timeout;
  logic [7:0]  round_count;
`ifdef POKER_SCORE_EN
  logic [7:0]  score_p1;
  logic [7:0]  score_p2;

  modport slave (
    input  start_button, rand_in, eval_done,
    input  winner_in, tie_in,
    output card_wr_en, card_wr_idx, card_wr_num,
    output start_computation, busy, result_valid,
    output winner, tie, eval_timeout, round_count,
    output score_p1, score_p2
  );

  modport master (
    output start_button, rand_in, eval_done,
    output winner_in, tie_in,
    input  card_wr_en, card_wr_idx, card_wr_num,
    input  start_computation, busy, result_valid,
    input  winner, tie, eval_timeout, round_count,
    input  score_p1, score_p2
  );
`else
  modport slave (
    input  start_button, rand_in, eval_done,
    input  winner_in, tie_in,
    output card_wr_en, card_wr_idx, card_wr_num,
    output start_computation, busy, result_valid,
    output winner, tie, eval_timeout, round_count
  );

  modport master (
    output start_button, rand_in, eval_done,
    output winner_in, tie_in,
    input  card_wr_en, card_wr_idx, card_wr_num,
    input  start_computation, busy, result_valid,
    input  winner, tie, eval_timeout, round_count
  );
`endif
endinterface

// File: rtl/poker_deal_sequencer.sv
// Poker round sequencer: deals 9 unique cards from an RNG, starts the
// evaluator, waits for its result (with timeout) and keeps round status.
// Ports: clk, rst (sync, active-high), bus (poker_deal_sequencer_if.slave).
// Optional POKER_SCORE_EN adds saturating per-player win tallies.
module poker_deal_sequencer (
  input  logic                         clk,
  input  logic                         rst,
  poker_deal_sequencer_if.slave        bus
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    DEAL,
    COMPUTE,
    WAIT_EVAL,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [51:0] used;
  logic [63:0] used_ext;
  logic [51:0] pick;
  logic [3:0]  slot;
  logic [7:0]  wcnt;
  logic        start_q;
  logic        armed;

  logic [5:0]  cand;
  logic        start_req;
  logic        accept;
  logic        done_hit;
  logic        to_hit;
  logic        busy_nxt;

  logic        wr_en_q;
  logic [3:0]  wr_idx_q;
  logic [5:0]  wr_num_q;
  logic        start_comp_q;
  logic        busy_q;
  logic        res_valid_q;
  logic        winner_q;
  logic        tie_q;
  logic        timeout_q;
  logic [7:0]  rounds_q;

  // armed stays low after reset until the button is seen released,
  // so a button held through reset never counts as a press.
  assign start_req = bus.start_button & ~start_q & armed;

  assign cand = bus.rand_in[5:0];

  // Codes 52..63 look permanently used, which rejects them for free.
  assign used_ext = {12'hfff, used};
  assign pick     = 52'd1 << cand;
  assign accept   = (state == DEAL) && !used_ext[cand];

  assign done_hit = (state == WAIT_EVAL) && bus.eval_done;
  assign to_hit   = (state == WAIT_EVAL) && !bus.eval_done
                    && (wcnt == 8'd254);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (start_req) state_nxt = CLEAR;
      CLEAR:     state_nxt = DEAL;
      DEAL:      if (accept && slot == 4'd8) state_nxt = COMPUTE;
      COMPUTE:   state_nxt = WAIT_EVAL;
      WAIT_EVAL: begin
        if (done_hit)    state_nxt = DONE;
        else if (to_hit) state_nxt = IDLE;
      end
      DONE:      if (start_req) state_nxt = CLEAR;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_nxt = 1'b0;
    unique case (1'b1)
      state_nxt == CLEAR,
      state_nxt == DEAL,
      state_nxt == COMPUTE,
      state_nxt == WAIT_EVAL: busy_nxt = 1'b1;
      default:                busy_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      used         <= '0;
      slot         <= '0;
      wcnt         <= '0;
      start_q      <= 1'b0;
      armed        <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_idx_q     <= '0;
      wr_num_q     <= '0;
      start_comp_q <= 1'b0;
      busy_q       <= 1'b0;
      res_valid_q  <= 1'b0;
      winner_q     <= 1'b0;
      tie_q        <= 1'b0;
      timeout_q    <= 1'b0;
      rounds_q     <= '0;
    end else begin
      start_q      <= bus.start_button;
      if (!bus.start_button) armed <= 1'b1;
      wr_en_q      <= accept;
      start_comp_q <= (state_nxt == COMPUTE);
      busy_q       <= busy_nxt;
      res_valid_q  <= done_hit;
      if (state == CLEAR) begin
        used      <= '0;
        slot      <= '0;
        timeout_q <= 1'b0;
      end
      if (accept) begin
        used     <= used | pick;
        slot     <= slot + 4'd1;
        wr_idx_q <= slot;
        wr_num_q <= cand;
      end
      if (state == COMPUTE)
        wcnt <= '0;
      else if (state == WAIT_EVAL && !bus.eval_done)
        wcnt <= wcnt + 8'd1;
      if (to_hit) timeout_q <= 1'b1;
      if (done_hit) begin
        winner_q <= bus.winner_in;
        tie_q    <= bus.tie_in;
        if (rounds_q != 8'hff) rounds_q <= rounds_q + 8'd1;
      end
    end
  end

  assign bus.card_wr_en        = wr_en_q;
  assign bus.card_wr_idx       = wr_idx_q;
  assign bus.card_wr_num       = wr_num_q;
  assign bus.start_computation = start_comp_q;
  assign bus.busy              = busy_q;
  assign bus.result_valid      = res_valid_q;
  assign bus.winner            = winner_q;
  assign bus.tie               = tie_q;
  assign bus.eval_timeout      = timeout_q;
  assign bus.round_count       = rounds_q;

`ifdef POKER_SCORE_EN
  logic [7:0] s1_q;
  logic [7:0] s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else if (done_hit && !bus.tie_in) begin
      if (!bus.winner_in && s1_q != 8'hff) s1_q <= s1_q + 8'd1;
      if (bus.winner_in && s2_q != 8'hff)  s2_q <= s2_q + 8'd1;
    end
  end

  assign bus.score_p1 = s1_q;
  assign bus.score_p2 = s2_q;
`endif

endmodule

// File: tb/tb_poker_deal_sequencer.sv
// Randomized bench for poker_deal_sequencer against a deck/round model.
// Build with or without POKER_SCORE_EN.
module tb_poker_deal_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  poker_deal_sequencer_if bus();

  poker_deal_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // round-level model state
  int m_rounds;
  int m_s1;
  int m_s2;
  bit m_win;
  bit m_tie;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    m_rounds = 0;
    m_s1 = 0;
    m_s2 = 0;
    m_win = 0;
    m_tie = 0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_wr_en"}, 32'(bus.card_wr_en), 0);
    chk({tag, "_wr_idx"}, 32'(bus.card_wr_idx), 0);
    chk({tag, "_wr_num"}, 32'(bus.card_wr_num), 0);
    chk({tag, "_sc"}, 32'(bus.start_computation), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_rv"}, 32'(bus.result_valid), 0);
    chk({tag, "_win"}, 32'(bus.winner), 0);
    chk({tag, "_tie"}, 32'(bus.tie), 0);
    chk({tag, "_to"}, 32'(bus.eval_timeout), 0);
    chk({tag, "_rc"}, 32'(bus.round_count), 0);
`ifdef POKER_SCORE_EN
    chk({tag, "_s1"}, 32'(bus.score_p1), 0);
    chk({tag, "_s2"}, 32'(bus.score_p2), 0);
`endif
  endtask

  task automatic check_held(input string tag);
    chk({tag, "_win"}, 32'(bus.winner), 32'(m_win));
    chk({tag, "_tie"}, 32'(bus.tie), 32'(m_tie));
    chk({tag, "_rc"}, 32'(bus.round_count), 32'(m_rounds));
`ifdef POKER_SCORE_EN
    chk({tag, "_s1"}, 32'(bus.score_p1), 32'(m_s1));
    chk({tag, "_s2"}, 32'(bus.score_p2), 32'(m_s2));
`endif
  endtask

  // Press start and deal a round. Cards come from seq first, then
  // random words. The model keeps the dealt hand as a plain list.
  task automatic run_deal(input int seq[$],
                          input int abort_at,
                          input bit hold);
    int dealt[$];
    int k;
    int v;
    int c;
    bit acc;
    k = 0;
    bus.start_button = 1'b1;
    tick;
    chk("busy_clear", 32'(bus.busy), 1);
    if (!hold) bus.start_button = 1'b0;
    tick;
    chk("busy_deal", 32'(bus.busy), 1);
    chk("to_cleared", 32'(bus.eval_timeout), 0);
    chk("wr_clear", 32'(bus.card_wr_en), 0);
    while (dealt.size() < 9) begin
      if (k < seq.size()) v = seq[k];
      else v = int'($urandom_range(0, 65535));
      k++;
      bus.rand_in   = v[15:0];
      bus.eval_done = 1'($urandom_range(0, 1));
      tick;
      c = v % 64;
      acc = (c < 52);
      foreach (dealt[i]) if (dealt[i] == c) acc = 1'b0;
      chk("wr_en", 32'(bus.card_wr_en), 32'(acc));
      if (acc) begin
        chk("wr_idx", 32'(bus.card_wr_idx), 32'(dealt.size()));
        chk("wr_num", 32'(bus.card_wr_num), 32'(c));
        dealt.push_back(c);
      end
      chk("start_comp", 32'(bus.start_computation),
          32'(dealt.size() == 9));
      chk("rv_deal", 32'(bus.result_valid), 0);
      if (abort_at != 0 && dealt.size() == abort_at) begin
        bus.eval_done = 1'b0;
        return;
      end
    end
    bus.eval_done = 1'b0;
  endtask

  // eval_done arrives d cycles after the start_computation cycle.
  task automatic run_eval(input int d, input bit w, input bit t);
    for (int i = 0; i < d; i++) begin
      tick;
      chk("busy_wait", 32'(bus.busy), 1);
      chk("rv_wait", 32'(bus.result_valid), 0);
      chk("sc_once", 32'(bus.start_computation), 0);
    end
    bus.eval_done = 1'b1;
    bus.winner_in = w;
    bus.tie_in    = t;
    tick;
    bus.eval_done = 1'b0;
    bus.winner_in = 1'($urandom_range(0, 1));
    bus.tie_in    = 1'($urandom_range(0, 1));
    if (m_rounds < 255) m_rounds++;
    m_win = w;
    m_tie = t;
    if (!t && !w && m_s1 < 255) m_s1++;
    if (!t && w && m_s2 < 255) m_s2++;
    chk("rv_pulse", 32'(bus.result_valid), 1);
    chk("busy_done", 32'(bus.busy), 0);
    chk("to_done", 32'(bus.eval_timeout), 0);
    check_held("res");
    tick;
    chk("rv_once", 32'(bus.result_valid), 0);
    check_held("hold");
  endtask

  task automatic run_timeout;
    for (int i = 1; i <= 256; i++) begin
      tick;
      chk("to_flag", 32'(bus.eval_timeout), 32'(i == 256));
      chk("to_busy", 32'(bus.busy), 32'(i != 256));
      chk("to_rv", 32'(bus.result_valid), 0);
    end
    check_held("to");
  endtask

  int basic_arr[13] = '{3, 3, 60, 17, 51, 0, 8, 9, 10, 11, 12, 52, 40};
  int basic_q[$];
  int none_q[$];

  initial begin
    rst = 1'b1;
    bus.start_button = 1'b0;
    bus.rand_in   = '0;
    bus.eval_done = 1'b0;
    bus.winner_in = 1'b0;
    bus.tie_in    = 1'b0;
    model_reset();
    tick;
    tick;
    check_zero("rst");
    rst = 1'b0;
    tick;

    // fixed deal then player2 win five cycles later
    foreach (basic_arr[i]) basic_q.push_back(basic_arr[i]);
    run_deal(basic_q, 0, 1'b0);
    run_eval(5, 1'b1, 1'b0);

    // random rounds, outcomes and evaluator latency
    for (int r = 0; r < 6; r++) begin
      run_deal(none_q, 0, 1'b0);
      run_eval(int'($urandom_range(1, 254)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
    end

    // eval_done on the last allowed cycle beats the timeout
    run_deal(none_q, 0, 1'b0);
    run_eval(255, 1'b1, 1'b0);

    // timeout, then eval_done in IDLE must be ignored
    run_deal(none_q, 0, 1'b0);
    run_timeout();
    for (int i = 0; i < 4; i++) begin
      bus.eval_done = 1'b1;
      tick;
      chk("idle_rv", 32'(bus.result_valid), 0);
      chk("idle_busy", 32'(bus.busy), 0);
    end
    bus.eval_done = 1'b0;
    check_held("idle");

    // a round starts straight from IDLE after the timeout
    run_deal(none_q, 0, 1'b0);
    run_eval(2, 1'b1, 1'b1);

    // reset after the 4th write, then a clean deal from slot 0
    run_deal(none_q, 4, 1'b0);
    rst = 1'b1;
    tick;
    check_zero("mid_rst");
    rst = 1'b0;
    model_reset();
    tick;
    run_deal(none_q, 0, 1'b0);
    run_eval(3, 1'b1, 1'b0);

    // button held across reset and through DONE
    rst = 1'b1;
    bus.start_button = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("held_rst_busy", 32'(bus.busy), 0);
    end
    bus.start_button = 1'b0;
    tick;
    run_deal(none_q, 0, 1'b1);
    run_eval(2, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("held_done_busy", 32'(bus.busy), 0);
      chk("held_done_rv", 32'(bus.result_valid), 0);
    end
    bus.start_button = 1'b0;
    tick;
    run_deal(none_q, 0, 1'b0);
    run_eval(1, 1'b1, 1'b0);

    // saturation of round_count and player1 score
    rst = 1'b1;
    tick;
    rst = 1'b0;
    model_reset();
    tick;
    for (int r = 0; r < 256; r++) begin
      run_deal(none_q, 0, 1'b0);
      run_eval(int'($urandom_range(1, 3)), 1'b0, 1'b0);
    end
    chk("sat_rc", 32'(bus.round_count), 255);
`ifdef POKER_SCORE_EN
    chk("sat_s1", 32'(bus.score_p1), 255);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
